tile_feed_reader: RTL and testbench
===================================

Name: tile_feed_reader

Overview:
- Memory-side initiator paired with the 16-bit data memory, which is a single-port responder with combinational read and clocked write.
- Fetches one N x N operand tile from the memory, one word per cycle, into an internal register tile.
- Then streams the tile into the systolic array's row inputs in diagonally skewed order: lane i is delayed by i beats.
- Sits between the data memory and the west edge of the 4x4 array; one instance per operand.

Parameters:
- DATA_W, 16, memory word width and lane width.
- ADDR_W, 16, memory address width.
- N, 4, tile dimension; number of output lanes.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst_n  input  1  reset, asynchronous, active-low.
- start  input  1  one-cycle request to load and feed a tile; sampled only in IDLE.
- base_addr  input  ADDR_W  address of tile element [0][0]; captured on an accepted start.
- row_stride  input  ADDR_W  address distance between tile rows; captured on an accepted start.
- feed_en  input  1  advances the feed by one beat when high in FEED; acts as a stall when low.
- mem_addr  output  ADDR_W  memory address, driven from a register.
- mem_we  output  1  memory write enable; constant 0.
- mem_rdata  input  DATA_W  memory read data, valid in the same cycle as mem_addr.
- lane_data  output  N*DATA_W  skewed feed; lane i occupies bits [i*DATA_W +: DATA_W].
- lane_valid  output  N  per-lane valid bit, aligned with lane_data.
- busy  output  1  high in FETCH and FEED.
- done  output  1  one-cycle pulse when the feed completes.

Behaviour:
- Reset values: state=IDLE; mem_addr=0; mem_we=0; lane_data=0; lane_valid=0; busy=0; done=0; tile registers=0.
- Reset asserted mid-operation aborts immediately to IDLE with all reset values; no done pulse is produced.
- States: IDLE, FETCH, FEED.
- IDLE -> FETCH:
  - Taken on start=1.
  - Capture base_addr and row_stride; r=c=0; mem_addr<=base_addr.
- start while busy=1 is ignored; it is not queued.
- FETCH, each cycle:
  - tile[r][c]<=mem_rdata.
  - Advance c, then r, in row-major order.
  - mem_addr<=base+r'*stride+c' for the next element (r', c').
- FETCH lasts exactly N*N cycles (16 at defaults), then goes to FEED with beat k=0.
- Address arithmetic is modulo 2^ADDR_W; wrap-around is legal and not flagged.
- FEED, on a cycle with feed_en=1, for each lane i:
  - lane_valid[i]<=(0<=k-i<N).
  - lane i data<=tile[i][k-i] if valid, else 0.
  - k increments.
- FEED, on a cycle with feed_en=0: lane_data and lane_valid are forced to 0, and k holds.
- Last beat is k=2N-2 (beat 6 at defaults).
- On the clock edge after the last beat issues: lanes are cleared to 0, done=1 for one cycle, state=IDLE.
- A start arriving in that same cycle (done=1) is accepted; done and the new FETCH overlap.
- Latency from an accepted start to the first valid lane: N*N+1 cycles with feed_en held high.
- mem_addr holds its last value in IDLE and FEED.

Optional Feature:
- Macro TILE_FEED_TRANSPOSE_EN.
- When defined, FETCH stores tile[c][r]<=mem_rdata, so lanes carry tile columns. This feeds the B operand from a row-major matrix without a memory re-layout; fetch address order is unchanged.
- When undefined, the block stores tile[r][c] only, with no transpose logic present.

Decomposition:
- Shared package: state enum (IDLE/FETCH/FEED), DATA_W/ADDR_W/N defaults, and a helper constant FEED_BEATS=2N-1.
- One natural sub-module: tile_feed_skew. It holds the N x N tile registers plus the beat counter, and produces lane_data and lane_valid from k.
- The top level keeps the FSM and the address generator.

Test Plan:
- Memory preloaded with mem[0x10+i]=i for i=0..15; start with base=0x10, stride=4, feed_en=1:
  - beat0 lanes={0,-,-,-}, valid=0001;
  - beat3 lanes={3,6,9,12}, valid=1111;
  - beat6 lane3=15, valid=1000;
  - done pulses at cycle 24 after start.
- base=0x20, stride=8: mem_addr sequence 0x20-0x23, 0x28-0x2B, 0x30-0x33, 0x38-0x3B; mem_we stays 0 throughout.
- base=0xFFFE, stride=4: addresses wrap to 0xFFFE, 0xFFFF, 0x0000, 0x0001, ...; data is captured correctly across the wrap.
- feed_en=0 for 3 cycles at beat 2: lanes are 0 and valid=0000 during the stall; beat 2 resumes with lanes {2,5,8,-}; total valid beats remain 7.
- rst_n deasserted at FETCH element 5: busy=0 immediately, no done pulse; a fresh start after release produces the full correct sequence.
- With TILE_FEED_TRANSPOSE_EN, same preload as the first scenario: beat3 lanes={12,9,6,3}.

Source files
------------

// File: rtl/tile_feed_reader_pkg.sv
// rtl/tile_feed_reader_pkg.sv - shared defaults, FSM states and feed-length helper for tile_feed_reader.
package tile_feed_reader_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 16;
  localparam int N_DEF      = 4;

  // A skewed N-lane feed spans 2N-1 beats: lane N-1 starts N-1 beats late.
  function automatic int feed_beats(input int n);
    return 2 * n - 1;
  endfunction

  localparam int FEED_BEATS = feed_beats(N_DEF);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    FEED  = 2'd2
  } state_t;

endpackage

// File: rtl/tile_feed_skew.sv
// rtl/tile_feed_skew.sv - N x N tile store and beat counter producing diagonally skewed lanes.
// Build option TILE_FEED_TRANSPOSE_EN stores the fetched tile transposed (lanes carry columns).
module tile_feed_skew
  import tile_feed_reader_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int N      = N_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    wr_en,
  input  logic [$clog2(N)-1:0]    wr_row,
  input  logic [$clog2(N)-1:0]    wr_col,
  input  logic [DATA_W-1:0]       wr_data,
  input  logic                    beat_clr,
  input  logic                    beat_adv,
  output logic [N*DATA_W-1:0]     lane_data,
  output logic [N-1:0]            lane_valid,
  output logic                    beat_done
);

  localparam int CW    = $clog2(N);
  localparam int KW    = $clog2(2 * N);
  localparam int BEATS = feed_beats(N);

  logic [DATA_W-1:0]   tile [N][N];
  logic [KW-1:0]       k;
  logic [KW-1:0]       col;
  logic [N*DATA_W-1:0] nxt_data;
  logic [N-1:0]        nxt_valid;

  assign beat_done = (k == KW'(BEATS));

  // Lane i shows column k-i of row i while that column is inside the tile.
  always_comb begin
    nxt_data  = '0;
    nxt_valid = '0;
    col       = '0;
    for (int i = 0; i < N; i++) begin
      col = k - KW'(i);
      if (k >= KW'(i) && col < KW'(N)) begin
        nxt_valid[i]                   = 1'b1;
        nxt_data[i*DATA_W +: DATA_W]   = tile[i][col[CW-1:0]];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k          <= '0;
      lane_data  <= '0;
      lane_valid <= '0;
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < N; j++) begin
          tile[i][j] <= '0;
        end
      end
    end else begin
      if (wr_en) begin
`ifdef TILE_FEED_TRANSPOSE_EN
        tile[wr_col][wr_row] <= wr_data;
`else
        tile[wr_row][wr_col] <= wr_data;
`endif
      end
      if (beat_clr) begin
        k <= '0;
      end
      // Lanes are only non-zero for the cycle after a beat issues; stalls and finish clear them.
      if (beat_adv) begin
        k          <= k + KW'(1);
        lane_data  <= nxt_data;
        lane_valid <= nxt_valid;
      end else begin
        lane_data  <= '0;
        lane_valid <= '0;
      end
    end
  end

endmodule

// File: rtl/tile_feed_reader.sv
// rtl/tile_feed_reader.sv - fetches an N x N tile from data memory and feeds it skewed to the array.
// Build option TILE_FEED_TRANSPOSE_EN (handled in tile_feed_skew) feeds tile columns instead of rows.
module tile_feed_reader
  import tile_feed_reader_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int N      = N_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [ADDR_W-1:0]   base_addr,
  input  logic [ADDR_W-1:0]   row_stride,
  input  logic                feed_en,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic                mem_we,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic [N*DATA_W-1:0] lane_data,
  output logic [N-1:0]        lane_valid,
  output logic                busy,
  output logic                done
);

  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  state_t            state_q, state_d;
  logic [CW-1:0]     r_q, c_q;
  logic [ADDR_W-1:0] row_addr_q, stride_q;
  logic              accept, fetch_last;
  logic              wr_en, beat_clr, beat_adv, beat_done, done_d;

  assign mem_we     = 1'b0;
  assign busy       = (state_q != IDLE);
  assign accept     = (state_q == IDLE) && start;
  assign fetch_last = (state_q == FETCH) && (r_q == LAST) && (c_q == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      done    <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    wr_en    = 1'b0;
    beat_clr = 1'b0;
    beat_adv = 1'b0;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = FETCH;
          beat_clr = 1'b1;
        end
      end
      FETCH: begin
        wr_en = 1'b1;
        if (fetch_last) state_d = FEED;
      end
      FEED: begin
        if (beat_done) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          beat_adv = feed_en;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // row_addr_q tracks base + r*stride so the next address needs only one adder per step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_addr   <= '0;
      row_addr_q <= '0;
      stride_q   <= '0;
      r_q        <= '0;
      c_q        <= '0;
    end else if (accept) begin
      mem_addr   <= base_addr;
      row_addr_q <= base_addr;
      stride_q   <= row_stride;
      r_q        <= '0;
      c_q        <= '0;
    end else if (state_q == FETCH && !fetch_last) begin
      if (c_q == LAST) begin
        c_q        <= '0;
        r_q        <= r_q + CW'(1);
        row_addr_q <= row_addr_q + stride_q;
        mem_addr   <= row_addr_q + stride_q;
      end else begin
        c_q      <= c_q + CW'(1);
        mem_addr <= mem_addr + ADDR_W'(1);
      end
    end
  end

  tile_feed_skew #(
    .DATA_W (DATA_W),
    .N      (N)
  ) u_skew (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en      (wr_en),
    .wr_row     (r_q),
    .wr_col     (c_q),
    .wr_data    (mem_rdata),
    .beat_clr   (beat_clr),
    .beat_adv   (beat_adv),
    .lane_data  (lane_data),
    .lane_valid (lane_valid),
    .beat_done  (beat_done)
  );

endmodule

// File: tb/tb_tile_feed_reader.sv
// tb/tb_tile_feed_reader.sv - self-checking bench for tile_feed_reader (honours TILE_FEED_TRANSPOSE_EN).
module tb_tile_feed_reader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] base_addr;
  logic [15:0] row_stride;
  logic        feed_en;
  logic [15:0] mem_addr;
  logic        mem_we;
  logic [15:0] mem_rdata;
  logic [63:0] lane_data;
  logic [3:0]  lane_valid;
  logic        busy;
  logic        done;

  logic [15:0] mem [0:65535];
  assign mem_rdata = mem[mem_addr];

  always #5 clk = ~clk;

  tile_feed_reader #(.DATA_W(16), .ADDR_W(16), .N(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .base_addr  (base_addr),
    .row_stride (row_stride),
    .feed_en    (feed_en),
    .mem_addr   (mem_addr),
    .mem_we     (mem_we),
    .mem_rdata  (mem_rdata),
    .lane_data  (lane_data),
    .lane_valid (lane_valid),
    .busy       (busy),
    .done       (done)
  );

  typedef struct {
    logic [63:0] data;
    logic [3:0]  valid;
  } beat_t;

  typedef struct {
    logic [15:0] base;
    logic [15:0] stride;
    int          stall_beat;
    int          stall_len;
    logic [15:0] offset;
    bit          poke;
  } vec_t;

  beat_t exp_q[$];
  beat_t mon_b;
  vec_t  vecs[5];
  int    n_vec = 0;
  int    n_err = 0;
  int    beats_seen = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Tile element (r,c) holds offset + 4r + c at address base + r*stride + c.
  function automatic logic [15:0] elem(input logic [15:0] offset, input int r, input int c);
    return offset + 16'(r * 4 + c);
  endfunction

  task automatic preload(input vec_t v);
    logic [15:0] a;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        a = v.base + 16'(r) * v.stride + 16'(c);
        mem[a] = elem(v.offset, r, c);
      end
    end
  endtask

  task automatic push_expected(input logic [15:0] offset);
    beat_t b;
    int    j;
    for (int k = 0; k < 7; k++) begin
      b.data  = '0;
      b.valid = '0;
      for (int i = 0; i < 4; i++) begin
        j = k - i;
        if (j >= 0 && j < 4) begin
          b.valid[i] = 1'b1;
`ifdef TILE_FEED_TRANSPOSE_EN
          b.data[i*16 +: 16] = elem(offset, j, i);
`else
          b.data[i*16 +: 16] = elem(offset, i, j);
`endif
        end
      end
      exp_q.push_back(b);
    end
  endtask

  // Starts on the current negedge (so back-to-back calls start in the done cycle) and returns on done.
  task automatic run_vec(input vec_t v);
    int          n;
    int          issued;
    int          stall_left;
    bit          seen_done;
    logic [15:0] a;
    logic [15:0] last_a;
    preload(v);
    push_expected(v.offset);
    beats_seen = 0;
    base_addr  = v.base;
    row_stride = v.stride;
    start      = 1'b1;
    feed_en    = 1'b1;
    n          = 0;
    issued     = 0;
    stall_left = v.stall_len;
    seen_done  = 1'b0;
    last_a     = v.base + 16'(3) * v.stride + 16'(3);
    while (!seen_done && n < 200) begin
      @(negedge clk);
      n++;
      start = 1'b0;
      if (n == 1) chk("done_pulse_width", {63'd0, done}, 64'd0);
      if (v.poke && n == 5) begin
        start     = 1'b1;
        base_addr = 16'h5555;
      end
      if (n >= 1 && n <= 16) begin
        a = v.base + 16'((n - 1) / 4) * v.stride + 16'((n - 1) % 4);
        chk("fetch_addr", {48'd0, mem_addr}, {48'd0, a});
        chk("mem_we", {63'd0, mem_we}, 64'd0);
        chk("busy_fetch", {63'd0, busy}, 64'd1);
      end
      if (n == 20) chk("addr_hold_feed", {48'd0, mem_addr}, {48'd0, last_a});
      if (done) begin
        seen_done = 1'b1;
        chk("done_cycle", 64'(n), 64'(25 + v.stall_len));
        chk("busy_at_done", {63'd0, busy}, 64'd0);
        chk("lanes_at_done", {60'd0, lane_valid}, 64'd0);
      end else if (n >= 17) begin
        if (issued == v.stall_beat && stall_left > 0) begin
          feed_en = 1'b0;
          stall_left--;
        end else begin
          feed_en = 1'b1;
          if (issued < 7) issued++;
        end
      end
    end
    chk("done_seen", {63'd0, seen_done}, 64'd1);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    chk("valid_beats", 64'(beats_seen), 64'd7);
    exp_q.delete();
    feed_en = 1'b1;
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (lane_valid != 4'b0) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_beat: got valid %b expected none", lane_valid);
        end else begin
          mon_b = exp_q.pop_front();
          chk("lane_valid", {60'd0, lane_valid}, {60'd0, mon_b.valid});
          chk("lane_data", lane_data, mon_b.data);
          beats_seen++;
        end
      end else if (busy) begin
        chk("lane_data_idle", lane_data, 64'd0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{base: 16'h0010, stride: 16'h0004, stall_beat: 0, stall_len: 0, offset: 16'h0000, poke: 1'b0};
    vecs[1] = '{base: 16'h0020, stride: 16'h0008, stall_beat: 0, stall_len: 0, offset: 16'h0100, poke: 1'b1};
    vecs[2] = '{base: 16'hFFFE, stride: 16'h0004, stall_beat: 0, stall_len: 0, offset: 16'h0200, poke: 1'b0};
    vecs[3] = '{base: 16'h0010, stride: 16'h0004, stall_beat: 2, stall_len: 3, offset: 16'h0000, poke: 1'b0};
    vecs[4] = '{base: 16'h1000, stride: 16'hFFF0, stall_beat: 6, stall_len: 1, offset: 16'h0400, poke: 1'b0};

    for (int i = 0; i < 65536; i++) mem[i] = 16'h0;

    rst_n      = 1'b0;
    start      = 1'b0;
    base_addr  = 16'h0;
    row_stride = 16'h0;
    feed_en    = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_mem_addr", {48'd0, mem_addr}, 64'd0);
    chk("rst_mem_we", {63'd0, mem_we}, 64'd0);
    chk("rst_lane_data", lane_data, 64'd0);
    chk("rst_lane_valid", {60'd0, lane_valid}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_busy", {63'd0, busy}, 64'd0);

    // Table vectors run back to back: each start lands in the previous done cycle.
    for (int v = 0; v < 5; v++) run_vec(vecs[v]);

    // Reset mid-fetch at element 5 aborts with no done pulse.
    @(negedge clk);
    preload(vecs[0]);
    base_addr  = 16'h0010;
    row_stride = 16'h0004;
    start      = 1'b1;
    repeat (6) begin
      @(negedge clk);
      start = 1'b0;
    end
    chk("abort_elem5_addr", {48'd0, mem_addr}, 64'h15);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", {63'd0, busy}, 64'd0);
    chk("abort_mem_addr", {48'd0, mem_addr}, 64'd0);
    chk("abort_lane_valid", {60'd0, lane_valid}, 64'd0);
    repeat (2) begin
      @(negedge clk);
      chk("abort_no_done", {63'd0, done}, 64'd0);
    end
    rst_n = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("post_abort_no_done", {63'd0, done}, 64'd0);
      chk("post_abort_idle", {63'd0, busy}, 64'd0);
    end
    run_vec(vecs[0]);

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
